// File: rtl/alarm_time_counter_if.sv
// Set/run controls and time-of-day outputs of the alarm clock time keeper.
// The time keeper is the slave side; the alarm logic or a testbench is the master side.
interface alarm_time_counter_if;
  logic       ena;
  logic       fast;
  logic       set_valid;
  logic [4:0] set_hours;
  logic [5:0] set_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic       min_tick;
  logic       day_tick;
  logic       set_err;

  // set_valid is a one-sided request with no ready: a legal value is always
  // taken on the next edge and an illegal one is answered by a set_err pulse.
  modport master (
    output ena, fast, set_valid, set_hours, set_minutes,
    input  hours, minutes, seconds, sec_tick, min_tick, day_tick, set_err
  );

  modport slave (
    input  ena, fast, set_valid, set_hours, set_minutes,
    output hours, minutes, seconds, sec_tick, min_tick, day_tick, set_err
  );
endinterface

// File: rtl/alarm_time_counter.sv
// 24-hour time keeper: prescales the system clock to a 1 Hz tick and keeps
// hours/minutes/seconds, with a user load port that rejects illegal times.
module alarm_time_counter #(
  parameter int CLKS_PER_SEC = 10000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alarm_time_counter_if.slave  bus
);

  localparam int             PW      = $clog2(CLKS_PER_SEC);
  localparam logic [PW-1:0]  PS_LAST = PW'(CLKS_PER_SEC - 1);

  logic [PW-1:0] r_presc;
  logic [4:0]    r_hours;
  logic [5:0]    r_minutes;
  logic [5:0]    r_seconds;
  logic          r_sec_tick;
  logic          r_min_tick;
  logic          r_day_tick;
  logic          r_set_err;

  logic w_set_ok;
  logic w_set_bad;
  logic w_adv;
  logic w_sec_wrap;
  logic w_min_wrap;
  logic w_hr_wrap;

  assign w_set_ok   = bus.set_valid && (bus.set_hours <= 5'd23) && (bus.set_minutes <= 6'd59);
  assign w_set_bad  = bus.set_valid && !w_set_ok;
  assign w_adv      = bus.ena && (bus.fast || (r_presc == PS_LAST));
  assign w_sec_wrap = (r_seconds == 6'd59);
  assign w_min_wrap = (r_minutes == 6'd59);
  assign w_hr_wrap  = (r_hours == 5'd23);

  // A legal load wins over any second that falls due in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_set_ok) begin
      r_presc <= '0;
    end else if (w_adv) begin
      r_presc <= '0;
    end else if (bus.ena) begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hours   <= '0;
      r_minutes <= '0;
      r_seconds <= '0;
    end else if (w_set_ok) begin
      r_hours   <= bus.set_hours;
      r_minutes <= bus.set_minutes;
      r_seconds <= '0;
    end else if (w_adv) begin
      if (w_sec_wrap) begin
        r_seconds <= '0;
        if (w_min_wrap) begin
          r_minutes <= '0;
          r_hours   <= w_hr_wrap ? 5'd0 : r_hours + 5'd1;
        end else begin
          r_minutes <= r_minutes + 6'd1;
        end
      end else begin
        r_seconds <= r_seconds + 6'd1;
      end
    end
  end

  // Ticks are registered alongside the time so each one lines up with its value change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sec_tick <= 1'b0;
      r_min_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_set_err  <= w_set_bad;
      r_sec_tick <= w_adv && !w_set_ok;
      r_min_tick <= w_adv && !w_set_ok && w_sec_wrap;
      r_day_tick <= w_adv && !w_set_ok && w_sec_wrap && w_min_wrap && w_hr_wrap;
    end
  end

  assign bus.hours    = r_hours;
  assign bus.minutes  = r_minutes;
  assign bus.seconds  = r_seconds;
  assign bus.sec_tick = r_sec_tick;
  assign bus.min_tick = r_min_tick;
  assign bus.day_tick = r_day_tick;
  assign bus.set_err  = r_set_err;

endmodule
